// File: rtl/bram_pkg.sv
// ---------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the parametrised dual-port RAM wrapper:
//   seq_state_t      - post-reset sequencer states (clear sweep, normal run)
//   RDW_READ_FIRST   - same-port read-during-write returns the old word
//   RDW_WRITE_FIRST  - same-port read-during-write returns the merged word
//   nbytes()         - number of byte lanes in a data word
// ---------------------------------------------------------------------------
package bram_pkg;

  typedef enum logic [0:0] {
    SEQ_CLEAR = 1'b0,
    SEQ_RUN   = 1'b1
  } seq_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int nbytes(input int dbits);
    return dbits / 8;
  endfunction

endpackage

// File: rtl/bram_dp_core.sv
// ---------------------------------------------------------------------------
// bram_dp_core
// Bare byte-enabled true-dual-port array. Both ports read the word present
// before the edge (read-first, also across ports) into a registered output.
// When both ports write the same word, port 0 owns every byte it enables and
// port 1 fills in the remaining enabled bytes.
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset of the read registers only
//   a0/a1      word address
//   d0/d1      write data
//   wbe0/wbe1  per-byte write strobes (already qualified by enable/write)
//   re0/re1    read register update enable; output holds when low
//   q0/q1      registered read data
// ---------------------------------------------------------------------------
module bram_dp_core
  import bram_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 16,
  localparam int NB   = nbytes(DBITS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [ABITS-1:0] a0,
  input  logic [DBITS-1:0] d0,
  input  logic [NB-1:0]    wbe0,
  input  logic             re0,
  output logic [DBITS-1:0] q0,
  input  logic [ABITS-1:0] a1,
  input  logic [DBITS-1:0] d1,
  input  logic [NB-1:0]    wbe1,
  input  logic             re1,
  output logic [DBITS-1:0] q1
);

  logic [DBITS-1:0] mem [2**ABITS];

  // Port 1 bytes are scheduled first so that a port 0 write to the same byte
  // of the same word overrides it (last non-blocking assignment wins).
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wbe1[i]) mem[a1][8*i +: 8] <= d1[8*i +: 8];
      if (wbe0[i]) mem[a0][8*i +: 8] <= d0[8*i +: 8];
    end
  end

  // ---- stage p1: registered read-first outputs ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      q0 <= '0;
      q1 <= '0;
    end else begin
      if (re0) q0 <= mem[a0];
      if (re1) q1 <= mem[a1];
    end
  end

endmodule

// File: rtl/bram_dp_param.sv
// ---------------------------------------------------------------------------
// bram_dp_param
// Parametrised true-dual-port RAM wrapper for accelerator local memories.
// Adds byte write enables, selectable same-port read-during-write behaviour,
// an optional second output register, same-address collision flagging and a
// post-reset zero-fill sweep.
//
// Parameters:
//   ABITS       address width, depth = 2**ABITS words
//   DBITS       data width, multiple of 8
//   READ_LAT    1 or 2 cycles from access to data on Q
//   RDW_MODE    0 = read-first, 1 = write-first (same port only)
//   INIT_CLEAR  1 = zero-fill the array after reset before accepting traffic
//
// Ports:
//   CLK, RSTN                  clock, synchronous active-low reset
//   A0/D0/BE0/WE0/CE0 -> Q0    port 0 address/data/byte enables/write/enable
//   A1/D1/BE1/WE1/CE1 -> Q1    port 1, same as port 0
//   READY                      high once the clear sweep has finished
//   COLL                       registered one-cycle pulse on a same-address
//                              access where at least one port writes
// ---------------------------------------------------------------------------
module bram_dp_param
  import bram_pkg::*;
#(
  parameter int ABITS      = 10,
  parameter int DBITS      = 16,
  parameter int READ_LAT   = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1,
  localparam int NB        = nbytes(DBITS)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic [NB-1:0]    BE0,
  input  logic             WE0,
  input  logic             CE0,
  output logic [DBITS-1:0] Q0,
  input  logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] D1,
  input  logic [NB-1:0]    BE1,
  input  logic             WE1,
  input  logic             CE1,
  output logic [DBITS-1:0] Q1,
  output logic             READY,
  output logic             COLL
);

  localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);
  localparam bit LAT2        = (READ_LAT == 2);

  function automatic logic [DBITS-1:0] merge_bytes(
    input logic [DBITS-1:0] old_w,
    input logic [DBITS-1:0] new_w,
    input logic [NB-1:0]    be
  );
    logic [DBITS-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  // Clear sequencer
  seq_state_t       state_q, state_d;
  logic [ABITS-1:0] cnt_q, cnt_d;
  logic             run;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= (INIT_CLEAR != 0) ? SEQ_CLEAR : SEQ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEQ_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        state_d = SEQ_RUN;
      end
      default: begin
        state_d = SEQ_RUN;
      end
    endcase
  end

  assign run = (state_q == SEQ_RUN);

  // Per-port views of the user inputs so both ports share one description.
  logic [ABITS-1:0] a_in  [2];
  logic [DBITS-1:0] d_in  [2];
  logic [NB-1:0]    be_in [2];
  logic             we_in [2];
  logic             acc   [2];
  logic [NB-1:0]    wbe   [2];

  assign a_in[0]  = A0;
  assign a_in[1]  = A1;
  assign d_in[0]  = D0;
  assign d_in[1]  = D1;
  assign be_in[0] = BE0;
  assign be_in[1] = BE1;
  assign we_in[0] = WE0;
  assign we_in[1] = WE1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p] = run && (p == 0 ? CE0 : CE1);
      wbe[p] = (acc[p] && we_in[p]) ? be_in[p] : '0;
    end
  end

  // During the sweep the counter borrows port 0 for an all-lanes zero write;
  // the read registers stay frozen so Q keeps its reset value.
  logic [ABITS-1:0] core_a0;
  logic [DBITS-1:0] core_d0;
  logic [NB-1:0]    core_wbe0;
  logic [DBITS-1:0] core_q  [2];

  assign core_a0   = run ? A0     : cnt_q;
  assign core_d0   = run ? D0     : '0;
  assign core_wbe0 = run ? wbe[0] : '1;

  bram_dp_core #(
    .ABITS (ABITS),
    .DBITS (DBITS)
  ) u_core (
    .clk  (CLK),
    .rstn (RSTN),
    .a0   (core_a0),
    .d0   (core_d0),
    .wbe0 (core_wbe0),
    .re0  (acc[0]),
    .q0   (core_q[0]),
    .a1   (A1),
    .d1   (D1),
    .wbe1 (wbe[1]),
    .re1  (acc[1]),
    .q1   (core_q[1])
  );

  // ---- stage p1: bypass context captured alongside the array read ----
  // The bypass fields only move on an access so that an idle port keeps
  // presenting the same word; vld_p1 marks a fresh result for stage p2.
  logic             byp_p1 [2];
  logic [DBITS-1:0] wd_p1  [2];
  logic [NB-1:0]    be_p1  [2];
  logic             vld_p1 [2];
  logic [DBITS-1:0] q_p1   [2];
  logic [DBITS-1:0] q_p2   [2];
  logic             coll_p1;
  logic             ready_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int p = 0; p < 2; p++) begin
        byp_p1[p] <= 1'b0;
        wd_p1[p]  <= '0;
        be_p1[p]  <= '0;
        vld_p1[p] <= 1'b0;
      end
      coll_p1 <= 1'b0;
      ready_q <= (INIT_CLEAR == 0);
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_p1[p] <= acc[p];
        if (acc[p]) begin
          byp_p1[p] <= WRITE_FIRST && we_in[p];
          wd_p1[p]  <= d_in[p];
          be_p1[p]  <= be_in[p];
        end
      end
      coll_p1 <= run && CE0 && CE1 && (A0 == A1) && (WE0 || WE1);
      ready_q <= run;
    end
  end

  // Write-first overlays this port's own enabled bytes on the old word the
  // array returned; a port that only reads always sees the old word.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_p1[p] = byp_p1[p] ? merge_bytes(core_q[p], wd_p1[p], be_p1[p])
                          : core_q[p];
    end
  end

  // ---- stage p2: optional output register, loads only fresh results ----
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      for (int p = 0; p < 2; p++) q_p2[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (vld_p1[p]) q_p2[p] <= q_p1[p];
      end
    end
  end

  assign Q0    = LAT2 ? q_p2[0] : q_p1[0];
  assign Q1    = LAT2 ? q_p2[1] : q_p1[1];
  assign READY = ready_q;
  assign COLL  = coll_p1;

endmodule

// File: doc/bram_dp_param.md
Name: bram_dp_param

Overview:
- Parametrised true-dual-port on-chip RAM wrapper. Successor to the fixed 1024x16 dual-port BRAM wrappers used by accelerator private local memories.
- Adds configurable geometry, per-byte write enables, selectable read-during-write mode, optional output pipeline register, and same-address collision arbitration.
- Adds a post-reset clear sequencer that zero-fills the array before accepting traffic.

Parameters:
- ABITS, 10, address width; depth = 2**ABITS words.
- DBITS, 16, data width; must be a multiple of 8.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- INIT_CLEAR, 1, 1 = zero-fill all words after reset; 0 = ready immediately.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- A0  in  ABITS  port 0 address.
- D0  in  DBITS  port 0 write data.
- BE0  in  DBITS/8  port 0 byte write enables.
- WE0  in  1  port 0 write request.
- CE0  in  1  port 0 chip enable.
- Q0  out  DBITS  port 0 read data.
- A1, D1, BE1, WE1, CE1, Q1: same as port 0, for port 1.
- READY  out  1  high once the clear sequence has completed.
- COLL  out  1  one-cycle pulse on a same-address conflict.

Behaviour:
- Reset (RSTN low at a clock edge): Q0, Q1, COLL and all pipeline registers are cleared to 0. Array contents are not reset directly.
- READY resets to 0 if INIT_CLEAR=1, and to 1 if INIT_CLEAR=0.
- Sequencer states: CLEAR, RUN.
  - Reset enters CLEAR if INIT_CLEAR=1, otherwise RUN.
  - In CLEAR, an ABITS-wide counter starts at 0 and writes all-zeros to address cnt each cycle. When cnt = 2**ABITS-1 is written, the next state is RUN and READY rises on the following cycle.
  - In CLEAR, CE0/CE1 are ignored: no writes occur, and Q0/Q1 hold 0.
  - Reset asserted during CLEAR restarts the counter at 0.
- RUN, port p (p = 0, 1):
  - An access happens when CEp=1.
  - Write: WEp=1 updates byte i only where BEp[i]=1. WEp=1 with BEp=0 performs no write but still returns read data.
  - Read: every access returns data on Qp after READ_LAT edges.
  - READ_LAT=1: Qp is valid on the edge after the access.
  - READ_LAT=2: an additional output register follows, so data appears one cycle later.
  - With CEp=0, Qp holds its last value through the whole pipeline (no bubble zeroing).
  - Same-port write: the returned data follows RDW_MODE. Write-first returns the merged word (old bytes where BE=0, new bytes where BE=1).
- Cross-port collision: CE0=CE1=1, A0=A1, and at least one WE=1.
  - Both writing: port 0 wins for every byte it enables. Port 1 bytes not enabled by port 0 are still written.
  - One writing, other reading: the reader gets old data (read-first across ports), regardless of RDW_MODE.
  - COLL=1 for exactly one cycle, on the edge after the colliding access, registered. Two reads to the same address never set COLL.
- Address width: addresses are exactly ABITS bits, so there is no out-of-range case. The counter wraps only at the CLEAR terminal.
- Inputs are sampled directly at the clock edge, with no internal delay elements.

Decomposition:
- Shared package bram_pkg:
  - sequencer state enumeration (CLEAR, RUN);
  - RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1 constants;
  - function nbytes(DBITS) = DBITS/8.
- Sub-module bram_dp_core(ABITS, DBITS): a bare byte-enabled dual-port array with one-cycle read-first registered outputs and port-0-priority byte merge.
- The top level holds the CLEAR sequencer, input muxing (counter vs port 0 during CLEAR), the write-first bypass, the READ_LAT=2 output stage, and COLL generation.

Test Plan:
- Clear sweep: ABITS=4, INIT_CLEAR=1; release RSTN → READY rises exactly 17 cycles after the first edge with RSTN=1. Then read all 16 addresses → 0x0000 each. CE/WE pulses during CLEAR cause no write.
- Byte enables / latency: write A0=5, D0=0xABCD, BE0=2'b10; read A1=5 → Q1=0xAB00 after 1 edge with READ_LAT=1, and after 2 edges with READ_LAT=2. Q1 holds the value while CE1=0.
- RDW mode: at mem[3]=0x1111, port 0 writes 0x2222 to address 3 with BE=11 → Q0=0x1111 if RDW_MODE=0, 0x2222 if RDW_MODE=1. A following read gives 0x2222 in both modes.
- Dual-write collision: A0=A1=7, D0=0xAAAA BE0=01, D1=0x5555 BE1=11 → mem[7]=0x55AA, and COLL is high for exactly one cycle.
- Read/write collision: port 1 reads address 9 (old 0x1234) while port 0 writes 0xFFFF there → Q1=0x1234 and COLL=1. Same-address dual read → COLL stays 0.
- Reset mid-clear: assert RSTN=0 at counter value 8 for 1 cycle → counter restarts at 0, READY rises after a full 2**ABITS+1 cycles, Q0/Q1 = 0.
